ex_muldiv_unit: RTL and testbench

Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the ID/EX register-file operands and a decoded mul/div opcode, and owns the architectural HI/LO registers. It serves MFHI/MFLO reads and raises a stall request toward the hazard/pipeline-control logic while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 38 +++
 rtl/muldiv_iter_datapath.sv | 81 ++++++++
 rtl/ex_muldiv_unit.sv | 208 ++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared definitions for the EX-stage multiply/divide unit:
//               operation codes, FSM state encoding, default width and
//               iteration count, and a small op-decoding helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;
    localparam int MULDIV_ITER  = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MFHI  = 3'b100;
    localparam logic [2:0] OP_MFLO  = 3'b101;
    localparam logic [2:0] OP_MTHI  = 3'b110;
    localparam logic [2:0] OP_MTLO  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } muldiv_state_e;

    // True for the two-operand ops that treat their operands as signed.
    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_iter_datapath.sv
// ============================================================================
// Module      : muldiv_iter_datapath
// Description : Iterative shift register shared by multiply and divide.
//               Multiply: radix-2 shift-add, acc = {partial_hi, multiplier}.
//               Divide  : restoring shift-subtract, acc = {remainder, quotient}.
//               One step per cycle while en is high.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               load            - capture a (into acc low half) and b
//               en              - perform one iteration step
//               div_mode        - 1: divide step, 0: multiply step
//               a, b            - operand magnitudes (dividend/divisor)
//               acc             - 2*WIDTH result register
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_iter_datapath #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               en,
    input  logic               div_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;

    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_rem_ge;
    logic [WIDTH-1:0]   w_rem_sub;

    always_comb begin
        acc_d = acc_q;
        b_d   = b_q;

        // Carry out of the upper-half add becomes the new MSB after shifting.
        w_mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};

        // Remainder shifted left with the next dividend bit pulled in.
        // Remainder is always < divisor, so this fits in WIDTH+1 bits and a
        // successful subtract always leaves a result that fits in WIDTH bits.
        w_rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
        w_rem_ge  = (w_rem_sh >= {1'b0, b_q});
        w_rem_sub = w_rem_sh[WIDTH-1:0] - b_q;

        if (load) begin
            acc_d = {{WIDTH{1'b0}}, a};
            b_d   = b;
        end else if (en) begin
            if (div_mode) begin
                acc_d = {(w_rem_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0]),
                         acc_q[WIDTH-2:0], w_rem_ge};
            end else if (acc_q[0]) begin
                acc_d = {w_mul_sum, acc_q[WIDTH-1:1]};
            end else begin
                acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            b_q   <= '0;
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
        end
    end

    assign acc = acc_q;

endmodule

`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
// ============================================================================
// Module      : ex_muldiv_unit
// Description : EX-stage iterative multiply/divide unit owning HI/LO.
//               Accepts MULT/MULTU/DIV/DIVU (ITER+2 edges to result),
//               single-cycle MTHI/MTLO, combinational MFHI/MFLO, and raises
//               stall_req whenever a request arrives while busy.
// Ports       : clk, reset         - clock, synchronous active-high reset
//               start, flush       - request qualifier (req = start & ~flush)
//               op                 - operation code (muldiv_pkg OP_*)
//               rs_val, rt_val     - operands from ID/EX
//               stall_req, busy    - pipeline hold / iteration in progress
//               done               - one-cycle pulse after MUL/DIV writeback
//               hi, lo, mf_data    - architectural HI/LO and MF read data
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH,
    parameter int ITER  = MULDIV_ITER
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    output logic             stall_req,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mf_data
);

    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    muldiv_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div_op_q, div_op_d;
    logic             divzero_q, divzero_d;

    logic               w_req;
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic               w_div_zero_in;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_dp_load;
    logic               w_dp_en;
    logic [2*WIDTH-1:0] w_acc;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    assign w_req         = start & ~flush;
    assign w_signed      = op_is_signed(op);
    assign w_a_neg       = w_signed & rs_val[WIDTH-1];
    assign w_b_neg       = w_signed & rt_val[WIDTH-1];
    assign w_div_zero_in = (op == OP_DIV || op == OP_DIVU) && (rt_val == '0);

    // For a zero divisor the dividend goes in raw: the restoring algorithm
    // then leaves it untouched in the remainder half, which is exactly the
    // required HI value, and the quotient naturally fills with ones.
    assign w_a_mag = (w_a_neg && !w_div_zero_in) ? (~rs_val + 1'b1) : rs_val;
    assign w_b_mag = w_b_neg ? (~rt_val + 1'b1) : rt_val;

    assign w_dp_load = (state_q == ST_IDLE) && w_req && !op[2];
    assign w_dp_en   = (state_q == ST_MUL) || (state_q == ST_DIV);

    muldiv_iter_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk      (clk),
        .reset    (reset),
        .load     (w_dp_load),
        .en       (w_dp_en),
        .div_mode (state_q == ST_DIV),
        .a        (w_a_mag),
        .b        (w_b_mag),
        .acc      (w_acc)
    );

    // Sign correction of the unsigned magnitude result.
    always_comb begin
        w_prod   = neg_res_q ? (~w_acc + 1'b1) : w_acc;
        w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod[WIDTH-1:0];
        if (div_op_q) begin
            w_fix_hi = w_acc[2*WIDTH-1:WIDTH];
            w_fix_lo = w_acc[WIDTH-1:0];
            if (!divzero_q) begin
                if (neg_rem_q) begin
                    w_fix_hi = ~w_acc[2*WIDTH-1:WIDTH] + 1'b1;
                end
                if (neg_res_q) begin
                    w_fix_lo = ~w_acc[WIDTH-1:0] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div_op_d  = div_op_q;
        divzero_d = divzero_q;

        case (state_q)
            ST_IDLE: begin
                if (w_req) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            state_d   = ST_MUL;
                            cnt_d     = '0;
                            neg_res_d = w_a_neg ^ w_b_neg;
                            neg_rem_d = w_a_neg;
                            div_op_d  = 1'b0;
                            divzero_d = 1'b0;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d   = ST_DIV;
                            cnt_d     = '0;
                            neg_res_d = w_a_neg ^ w_b_neg;
                            neg_rem_d = w_a_neg;
                            div_op_d  = 1'b1;
                            divzero_d = w_div_zero_in;
                        end
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                hi_d    = w_fix_hi;
                lo_d    = w_fix_lo;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div_op_q  <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div_op_q  <= div_op_d;
            divzero_q <= divzero_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign stall_req = w_req & busy & ~reset;
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

    always_comb begin
        mf_data = '0;
        if (op == OP_MFHI) begin
            mf_data = hi_q;
        end else if (op == OP_MFLO) begin
            mf_data = lo_q;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
// ============================================================================
// Module      : tb_ex_muldiv_unit
// Description : Self-checking bench for ex_muldiv_unit. Expected HI/LO pairs
//               are queued when an operation is issued and compared when the
//               unit signals done.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_muldiv_unit;
    import muldiv_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        stall_req;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mf_data;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    ex_muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .flush     (flush),
        .stall_req (stall_req),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .mf_data   (mf_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    function automatic exp_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] p;
        int          sa, sbv;
        p = '0;
        e.hi = '0;
        e.lo = '0;
        case (o)
            OP_MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                e.hi = p[63:32]; e.lo = p[31:0];
            end
            OP_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                e.hi = p[63:32]; e.lo = p[31:0];
            end
            OP_DIV: begin
                if (b == 0) begin
                    e.hi = a; e.lo = 32'hFFFF_FFFF;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.hi = 32'h0; e.lo = 32'h8000_0000;
                end else begin
                    sa = a; sbv = b;
                    e.lo = sa / sbv; e.hi = sa % sbv;
                end
            end
            default: begin
                if (b == 0) begin
                    e.hi = a; e.lo = 32'hFFFF_FFFF;
                end else begin
                    e.lo = a / b; e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    function automatic exp_t mk(input logic [31:0] h, input logic [31:0] l);
        exp_t e;
        e.hi = h; e.lo = l;
        return e;
    endfunction

    // Called at posedge+1. Presents the request, checks it is not stalled,
    // and returns at posedge+1 after the accept edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; flush = 1'b0; op = o; rs_val = a; rt_val = b;
        #1;
        checks++;
        if (stall_req !== 1'b0) begin
            errors++;
            $display("FAIL issue_stall op=%0d stall_req=%b expected 0", o, stall_req);
        end
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_single_cycle done=%b expected 0", done);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_accept busy=%b expected 1", busy);
        end
    endtask

    // Waits for done; from cycle mf_from (if >0) holds an MFLO request and
    // expects it to be stalled while busy.
    task automatic wait_done(input int mf_from);
        int cycles;
        cycles = 1;
        while (done !== 1'b1 && cycles < 60) begin
            if (mf_from > 0 && cycles >= mf_from) begin
                start = 1'b1; op = OP_MFLO;
            end
            #1;
            if (mf_from > 0 && cycles >= mf_from) begin
                checks++;
                if (stall_req !== 1'b1) begin
                    errors++;
                    $display("FAIL mf_stall cycle=%0d stall_req=%b expected 1", cycles, stall_req);
                end
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_in_flight cycle=%0d busy=%b expected 1", cycles, busy);
            end
            @(posedge clk); #1;
            cycles++;
        end
        checks++;
        if (cycles != 34) begin
            errors++;
            $display("FAIL latency edges=%0d expected 34", cycles);
        end
    endtask

    task automatic finish_op(input bit mf);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty size=0 expected >0");
            return;
        end
        e = sb.pop_front();
        checks++;
        if (hi !== e.hi) begin
            errors++;
            $display("FAIL result_hi got=%h expected=%h", hi, e.hi);
        end
        checks++;
        if (lo !== e.lo) begin
            errors++;
            $display("FAIL result_lo got=%h expected=%h", lo, e.lo);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_in_done busy=%b expected 0", busy);
        end
        if (mf) begin
            checks++;
            if (mf_data !== e.lo) begin
                errors++;
                $display("FAIL mf_done_data got=%h expected=%h", mf_data, e.lo);
            end
            checks++;
            if (stall_req !== 1'b0) begin
                errors++;
                $display("FAIL mf_done_stall stall_req=%b expected 0", stall_req);
            end
            start = 1'b0;
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input exp_t e, input int mf_from);
        sb.push_back(e);
        issue(o, a, b);
        wait_done(mf_from);
        finish_op(mf_from > 0);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; op = OP_MFHI; flush = 1'b0;
        rs_val = 32'h5555_5555; rt_val = 32'h1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b expected 0", done); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h expected 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h expected 0", lo); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b expected 0", stall_req); end
        checks++; if (mf_data !== 32'h0) begin errors++; $display("FAIL reset_mf got=%h expected 0", mf_data); end
        reset = 1'b0; start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_multu();
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'h2, mk(32'h0000_0001, 32'hFFFF_FFFE), 0);
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse_once done=%b expected 0", done);
        end
    endtask

    task automatic test_mult_div();
        run_op(OP_MULT, 32'hFFFF_FFF9, 32'h3, mk(32'hFFFF_FFFF, 32'hFFFF_FFEB), 0);
        run_op(OP_DIV,  32'hFFFF_FFF9, 32'h2, mk(32'hFFFF_FFFF, 32'hFFFF_FFFD), 0);
        run_op(OP_DIVU, 32'd1000, 32'd7, mk(32'd6, 32'd142), 0);
    endtask

    task automatic test_boundaries();
        run_op(OP_DIVU, 32'd100, 32'h0, mk(32'd100, 32'hFFFF_FFFF), 0);
        run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, mk(32'h0, 32'h8000_0000), 0);
        run_op(OP_DIV,  32'hFFFF_FFF0, 32'h0, mk(32'hFFFF_FFF0, 32'hFFFF_FFFF), 0);
        run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, mk(32'h4000_0000, 32'h0), 0);
    endtask

    task automatic test_mf_stall();
        run_op(OP_MULT, 32'd1234, 32'hFFFF_FF00, model(OP_MULT, 32'd1234, 32'hFFFF_FF00), 5);
    endtask

    task automatic test_mt_flush();
        start = 1'b1; flush = 1'b0; op = OP_MTHI; rs_val = 32'h1234_5678;
        #1;
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL mt_stall got=%b expected 0", stall_req); end
        @(posedge clk); #1;
        checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi got=%h expected 12345678", hi); end
        op = OP_MTLO; rs_val = 32'hCAFE_F00D;
        @(posedge clk); #1;
        checks++; if (lo !== 32'hCAFE_F00D) begin errors++; $display("FAIL mtlo got=%h expected cafef00d", lo); end
        flush = 1'b1; op = OP_MTHI; rs_val = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL flush_mthi got=%h expected 12345678", hi); end
        op = OP_MULT; rs_val = 32'd5; rt_val = 32'd5;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_mult_busy got=%b expected 0", busy); end
        flush = 1'b0; start = 1'b0; op = OP_MFHI;
        #1;
        checks++; if (mf_data !== 32'h1234_5678) begin errors++; $display("FAIL mfhi_data got=%h expected 12345678", mf_data); end
        op = OP_MFLO;
        #1;
        checks++; if (mf_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL mflo_data got=%h expected cafef00d", mf_data); end
        op = OP_MTHI;
        #1;
        checks++; if (mf_data !== 32'h0) begin errors++; $display("FAIL mf_other_op got=%h expected 0", mf_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_div();
        int pulses;
        sb.push_back(model(OP_DIV, 32'd1000, 32'd7));
        issue(OP_DIV, 32'd1000, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1; start = 1'b1; op = OP_MFHI;
        #1;
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_mid_stall got=%b expected 0", stall_req); end
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy got=%b expected 0", busy); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_mid_hi got=%h expected 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_mid_lo got=%h expected 0", lo); end
        sb.delete();
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL reset_mid_done pulses=%0d expected 0", pulses); end
        run_op(OP_MULTU, 32'd3, 32'd4, mk(32'h0, 32'd12), 0);
    endtask

    // Each new op is issued in the done cycle of the previous one.
    task automatic test_back_to_back();
        logic [2:0]  o;
        logic [31:0] a, b;
        for (int i = 0; i < 8; i++) begin
            o = 3'($urandom_range(0, 3));
            a = $urandom;
            b = (i == 3) ? 32'h0 : ((i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            if (i == 5) a = 32'hFFFF_FF85;
            run_op(o, a, b, model(o, a, b), 0);
        end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult_div();
        test_boundaries();
        test_mf_stall();
        test_mt_flush();
        test_reset_mid_div();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
